// File: rtl/r_ptr_handler_if.sv
// Read-side pointer bundle between the FIFO read logic and its environment.
// Pure wiring, no latency; no backpressure (i_ren is qualified by empty_flag inside the handler).
// The slave modport is the handler itself; the master modport is the read-domain user/synchroniser.
interface r_ptr_handler_if #(
  parameter int ADDR_W = 3
);
  logic              i_ren;
  logic [ADDR_W:0]   g_w_ptr_sync;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   g_r_ptr;
  logic              empty_flag;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_count;
  logic              r_valid;
  logic              underflow;

  modport master (
    output i_ren, g_w_ptr_sync,
    input  r_addr, g_r_ptr, empty_flag, almost_empty, rd_count, r_valid, underflow
  );

  modport slave (
    input  i_ren, g_w_ptr_sync,
    output r_addr, g_r_ptr, empty_flag, almost_empty, rd_count, r_valid, underflow
  );
endinterface

// File: rtl/r_ptr_handler.sv
// Async-FIFO read-domain pointer and status flags (empty, almost-empty, occupancy, underflow).
// All outputs registered; r_valid follows an accepted read by one cycle (1-cycle sync RAM).
// Reads are accepted only while the registered empty_flag is low; reads while empty set underflow.
module r_ptr_handler #(
  parameter int ADDR_W    = 3,
  parameter int AEMPTY_TH = 1
) (
  input logic              i_rclk,
  input logic              i_rst,
  r_ptr_handler_if.slave   bus
);

  localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W:0] r_ptr_q,    r_ptr_d;
  logic [ADDR_W:0] g_r_ptr_q,  g_r_ptr_d;
  logic [ADDR_W:0] rd_count_q, rd_count_d;
  logic            empty_q,    empty_d;
  logic            aempty_q,   aempty_d;
  logic            r_valid_q,  r_valid_d;
  logic            underflow_q, underflow_d;
  logic            rd_accept;
  logic [ADDR_W:0] w_bin;

  // Next-state: advance on accepted read, decode the synced write pointer, derive status.
  always_comb begin
    rd_accept = bus.i_ren & ~empty_q;
    r_ptr_d   = r_ptr_q + {{ADDR_W{1'b0}}, rd_accept};
    g_r_ptr_d = r_ptr_d ^ (r_ptr_d >> 1);

    // Gray to binary: each bit is the XOR of all Gray bits from the MSB down to it.
    w_bin         = '0;
    w_bin[ADDR_W] = bus.g_w_ptr_sync[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ bus.g_w_ptr_sync[i];
    end

    // Status uses the post-read pointer so the draining edge raises empty immediately.
    empty_d     = (g_r_ptr_d == bus.g_w_ptr_sync);
    rd_count_d  = w_bin - r_ptr_d;
    aempty_d    = (rd_count_d <= AE_TH);
    r_valid_d   = rd_accept;
    underflow_d = underflow_q | (bus.i_ren & empty_q);
  end

  // State registers with synchronous reset; reset edge ignores i_ren and the write pointer.
  always_ff @(posedge i_rclk) begin
    if (i_rst) begin
      r_ptr_q     <= '0;
      g_r_ptr_q   <= '0;
      rd_count_q  <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      r_valid_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      g_r_ptr_q   <= g_r_ptr_d;
      rd_count_q  <= rd_count_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      r_valid_q   <= r_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.r_addr       = r_ptr_q[ADDR_W-1:0];
  assign bus.g_r_ptr      = g_r_ptr_q;
  assign bus.empty_flag   = empty_q;
  assign bus.almost_empty = aempty_q;
  assign bus.rd_count     = rd_count_q;
  assign bus.r_valid      = r_valid_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_r_ptr_handler.sv
// Directed bench for r_ptr_handler (ADDR_W=3, AEMPTY_TH=1).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Table vectors cover reset, basic reads, underflow and full-depth drain; hand sequences cover wrap and mid-read reset.
module tb_r_ptr_handler;

  logic i_rclk;
  logic i_rst;
  int   n_tests;
  int   n_fail;

  r_ptr_handler_if #(.ADDR_W(3)) bus ();

  r_ptr_handler #(.ADDR_W(3), .AEMPTY_TH(1)) dut (
    .i_rclk (i_rclk),
    .i_rst  (i_rst),
    .bus    (bus)
  );

  initial begin
    i_rclk = 1'b0;
    forever #5 i_rclk = ~i_rclk;
  end

  typedef struct packed {
    logic       rst;
    logic       ren;
    logic [3:0] gw;
    logic       e;
    logic       ae;
    logic [3:0] gr;
    logic [3:0] cnt;
    logic       rv;
    logic       uf;
    logic [2:0] addr;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ren, input logic [3:0] gw);
    i_rst            = rst;
    bus.i_ren        = ren;
    bus.g_w_ptr_sync = gw;
    @(posedge i_rclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".empty"},     int'(bus.empty_flag),   int'(v.e));
    chk({tag, ".aempty"},    int'(bus.almost_empty), int'(v.ae));
    chk({tag, ".g_r_ptr"},   int'(bus.g_r_ptr),      int'(v.gr));
    chk({tag, ".rd_count"},  int'(bus.rd_count),     int'(v.cnt));
    chk({tag, ".r_valid"},   int'(bus.r_valid),      int'(v.rv));
    chk({tag, ".underflow"}, int'(bus.underflow),    int'(v.uf));
    chk({tag, ".r_addr"},    int'(bus.r_addr),       int'(v.addr));
  endtask

  initial begin
    vec_t rv_exp;
    n_tests = 0;
    n_fail  = 0;
    i_rst            = 1'b1;
    bus.i_ren        = 1'b0;
    bus.g_w_ptr_sync = 4'b0000;

    //            rst   ren   gw       e     ae    gr       cnt    rv    uf    addr
    vecs[0]  = '{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0001, 4'd2, 1'b1, 1'b0, 3'd1};
    vecs[4]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0011, 4'd1, 1'b1, 1'b0, 3'd2};
    vecs[5]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'd0, 1'b1, 1'b0, 3'd3};
    vecs[6]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'd0, 1'b0, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'd0, 1'b0, 1'b1, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 4'b0010, 4'd1, 1'b0, 1'b1, 3'd3};
    vecs[9]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 4'b0110, 4'd0, 1'b1, 1'b1, 3'd4};
    vecs[10] = '{1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{1'b0, 1'b0, 4'b1100, 1'b0, 1'b0, 4'b0000, 4'd8, 1'b0, 1'b0, 3'd0};
    vecs[12] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0001, 4'd7, 1'b1, 1'b0, 3'd1};
    vecs[13] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0011, 4'd6, 1'b1, 1'b0, 3'd2};
    vecs[14] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0010, 4'd5, 1'b1, 1'b0, 3'd3};
    vecs[15] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0110, 4'd4, 1'b1, 1'b0, 3'd4};
    vecs[16] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0111, 4'd3, 1'b1, 1'b0, 3'd5};
    vecs[17] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0101, 4'd2, 1'b1, 1'b0, 3'd6};
    vecs[18] = '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 4'b0100, 4'd1, 1'b1, 1'b0, 3'd7};
    vecs[19] = '{1'b0, 1'b1, 4'b1100, 1'b1, 1'b1, 4'b1100, 4'd0, 1'b1, 1'b0, 3'd0};
    vecs[20] = '{1'b0, 1'b0, 4'b1100, 1'b1, 1'b1, 4'b1100, 4'd0, 1'b0, 1'b0, 3'd0};

    @(posedge i_rclk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].ren, vecs[i].gw);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Walk the read pointer from 8 to 15, one write step and one read at a time.
    for (int k = 8; k < 15; k++) begin
      step(1'b0, 1'b0, gray4(k + 1));
      chk($sformatf("walk%0d.empty_lo", k), int'(bus.empty_flag), 0);
      step(1'b0, 1'b1, gray4(k + 1));
      chk($sformatf("walk%0d.g_r_ptr", k), int'(bus.g_r_ptr), int'(gray4(k + 1)));
      chk($sformatf("walk%0d.empty_hi", k), int'(bus.empty_flag), 1);
    end
    chk("wrap.pre_g_r_ptr", int'(bus.g_r_ptr), 4'b1000);
    chk("wrap.pre_r_addr", int'(bus.r_addr), 7);

    // Write pointer wraps to 0; read across the 15 -> 0 boundary.
    step(1'b0, 1'b0, 4'b0000);
    rv_exp = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'd1, 1'b0, 1'b0, 3'd7};
    chk_all("wrap.avail", rv_exp);
    step(1'b0, 1'b1, 4'b0000);
    rv_exp = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b1, 1'b0, 3'd0};
    chk_all("wrap.read", rv_exp);

    // Advance to r_ptr=5, expose one more word, then reset together with a read request.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, gray4(k + 1));
      step(1'b0, 1'b1, gray4(k + 1));
    end
    chk("mid.g_r_ptr", int'(bus.g_r_ptr), 4'b0111);
    step(1'b0, 1'b0, 4'b0101);
    chk("mid.empty_lo", int'(bus.empty_flag), 0);
    chk("mid.rd_count", int'(bus.rd_count), 1);
    step(1'b1, 1'b1, 4'b0101);
    rv_exp = '{1'b1, 1'b1, 4'b0101, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 3'd0};
    chk_all("midrst", rv_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
